ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank_pkg.sv | 18 +
 rtl/ram_word.sv | 22 ++
 rtl/ram_bank.sv | 69 ++++++
 tb/tb_ram_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared constants and helpers for the ram_bank register-file slice.
package ram_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned COUNT_W       = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_word.sv
// One storage word: synchronous clear takes priority over load.
module ram_word
    import ram_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_bank.sv
// Register-file RAM with one write/read port A, one read port B and a saturating write counter.
// Define RAM_BANK_BYPASS_EN to forward write data to the read ports in the write cycle.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                in,
    input  logic                            load,
    input  logic [clog2(DEPTH)-1:0]         address,
    output logic [WIDTH-1:0]                out,
    input  logic [clog2(DEPTH)-1:0]         address_b,
    output logic [WIDTH-1:0]                out_b,
    output logic [COUNT_W-1:0]              writes
);

    localparam int unsigned ADDR_W = clog2(DEPTH);

    logic [DEPTH-1:0] word_load;
    logic [WIDTH-1:0] mem [DEPTH];

    // One-hot demux of load onto the addressed word
    always_comb begin
        word_load          = '0;
        word_load[address] = load;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clock(clock),
            .reset(reset),
            .load (word_load[i]),
            .d    (in),
            .q    (mem[i])
        );
    end

`ifdef RAM_BANK_BYPASS_EN
    logic fwd;
    assign fwd = load && !reset;

    always_comb begin
        out   = fwd ? in : mem[address];
        out_b = (fwd && (address_b == address)) ? in : mem[address_b];
    end
`else
    always_comb begin
        out   = mem[address];
        out_b = mem[address_b];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            writes <= '0;
        end else if (load && (writes != COUNT_MAX)) begin
            writes <= writes + 8'd1;
        end
    end

    logic unused_addr_w;
    assign unused_addr_w = (ADDR_W == 0);

endmodule

// File: tb/tb_ram_bank.sv
// Randomised bench for ram_bank against an array model, plus directed literal checks.
module tb_ram_bank;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset, load;
    logic [W-1:0]  in_d;
    logic [AW-1:0] address, address_b;
    logic [W-1:0]  out, out_b;
    logic [7:0]    writes;

    logic          reset2, load2;
    logic [7:0]    in2;
    logic [5:0]    address2, address2_b;
    logic [7:0]    out2, out2_b;
    logic [7:0]    writes2;

    int cmp_count = 0;
    int err_count = 0;
    bit chk_en    = 1'b0;

    logic [W-1:0] mem_m [D];
    int           w_m;

    always #5 clock = ~clock;

    ram_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .in(in_d), .load(load), .address(address),
        .out(out), .address_b(address_b), .out_b(out_b), .writes(writes)
    );

    ram_bank #(.WIDTH(8), .DEPTH(64)) dut2 (
        .clock(clock), .reset(reset2), .in(in2), .load(load2), .address(address2),
        .out(out2), .address_b(address2_b), .out_b(out2_b), .writes(writes2)
    );

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < D; i++) mem_m[i] <= '0;
            w_m <= 0;
        end else if (load) begin
            mem_m[address] <= in_d;
            if (w_m < 255) w_m <= w_m + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            logic [W-1:0] ea, eb;
            ea = mem_m[address];
            eb = mem_m[address_b];
`ifdef RAM_BANK_BYPASS_EN
            if (load && !reset) begin
                ea = in_d;
                if (address_b == address) eb = in_d;
            end
`endif
            check("model_out", 32'(out), 32'(ea));
            check("model_out_b", 32'(out_b), 32'(eb));
            check("model_writes", 32'(writes), 32'(w_m));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; in_d = '0; address = '0; address_b = '0;
        reset2 = 1'b1; load2 = 1'b0; in2 = '0; address2 = '0; address2_b = '0;
        step();
        reset = 1'b0; reset2 = 1'b0;
        chk_en = 1'b1;

        // Reset contents on both ports
        for (int a = 0; a < D; a++) begin
            address = AW'(a); address_b = AW'(D - 1 - a);
            @(negedge clock);
            check("rst_out", 32'(out), 32'h0);
            check("rst_out_b", 32'(out_b), 32'h0);
            check("rst_writes", 32'(writes), 32'h0);
            step();
        end

        // Single write, visible next cycle on both ports
        address = 3'd3; in_d = 16'h1234; load = 1'b1;
        step();
        load = 1'b0; address_b = 3'd3;
        @(negedge clock);
        check("wr3_out", 32'(out), 32'h1234);
        check("wr3_out_b", 32'(out_b), 32'h1234);
        check("wr3_writes", 32'(writes), 32'h1);
        for (int a = 0; a < D; a++) begin
            if (a != 3) begin
                address = AW'(a);
                #1 check("wr3_other", 32'(out), 32'h0);
            end
        end
        step();

        // Reset beats load
        address = 3'd5; in_d = 16'hBEEF; load = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; load = 1'b0; address_b = 3'd5;
        @(negedge clock);
        check("rstpri_out", 32'(out), 32'h0);
        check("rstpri_writes", 32'(writes), 32'h0);
        step();

        // Same-cycle read of the word being written
        address = 3'd2; in_d = 16'h0011; load = 1'b1;
        step();
        in_d = 16'h00AA; address_b = 3'd2;
        @(negedge clock);
`ifdef RAM_BANK_BYPASS_EN
        check("same_out", 32'(out), 32'h00AA);
        check("same_out_b", 32'(out_b), 32'h00AA);
`else
        check("same_out", 32'(out), 32'h0011);
        check("same_out_b", 32'(out_b), 32'h0011);
`endif
        step();
        load = 1'b0;
        @(negedge clock);
        check("after_out", 32'(out), 32'h00AA);
        step();

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 31) == 0);
            load      = $urandom_range(0, 1);
            in_d      = W'($urandom);
            address   = AW'($urandom);
            address_b = ($urandom_range(0, 3) == 0) ? address : AW'($urandom);
            step();
        end

        // Saturation of the write counter
        reset = 1'b1; load = 1'b0;
        step();
        reset = 1'b0; load = 1'b1;
        for (int n = 0; n < 300; n++) begin
            in_d = W'($urandom); address = AW'($urandom);
            step();
        end
        load = 1'b0;
        @(negedge clock);
        check("sat_writes", 32'(writes), 32'd255);
        step();
        step();
        @(negedge clock);
        check("sat_hold", 32'(writes), 32'd255);
        step();
        chk_en = 1'b0;

        // Wide-address instance: no aliasing between word 63 and word 0
        address2 = 6'd63; in2 = 8'hFF; load2 = 1'b1;
        step();
        address2 = 6'd0; in2 = 8'h01;
        step();
        load2 = 1'b0; address2 = 6'd63; address2_b = 6'd0;
        @(negedge clock);
        check("d64_out63", 32'(out2), 32'hFF);
        check("d64_out0", 32'(out2_b), 32'h01);
        check("d64_writes", 32'(writes2), 32'd2);
        address2 = 6'd31;
        #1 check("d64_out31", 32'(out2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
